laser_array_obstacle: RTL and testbench

//  Parametrised laser-sweep obstacle: N vertical lasers at fixed pitch, lit one at a time (or all at once),

---
 rtl/laser_array_obstacle_pkg.sv | 34 +++
 rtl/laser_array_obstacle_sequencer.sv | 156 +++++++++++++++
 rtl/laser_array_obstacle.sv | 122 ++++++++++++
 tb/tb_laser_array_obstacle.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/laser_array_obstacle_pkg.sv
// Shared types and constants for the laser array obstacle.
// Phase and sweep-mode encodings, screen defaults, width helpers.
package laser_array_obstacle_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SPAWN = 2'd1,
    ST_GROW  = 2'd2,
    ST_HOLD  = 2'd3
  } state_e;

  typedef enum logic [1:0] {
    MODE_PING = 2'b00,
    MODE_FWD  = 2'b01,
    MODE_REV  = 2'b10,
    MODE_ALL  = 2'b11
  } mode_e;

  localparam logic [11:0] DEF_LASER_TOP    = 12'd317;
  localparam logic [11:0] DEF_LASER_BOTTOM = 12'd617;
  localparam logic [11:0] RGB_WHITE        = 12'hfff;

  // Bits needed to hold values 0..n-1, never less than one.
  function automatic int w_of(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/laser_array_obstacle_sequencer.sv
// Laser sweep sequencer: phase FSM, shared delay counter,
// laser index / direction / repeat tracking and done pulse.
module laser_sequencer
  import laser_array_obstacle_pkg::*;
#(
  parameter int NUM_LASERS  = 3,
  parameter int GROW_STEPS  = 30,
  parameter int SPAWN_DELAY = 32000000,
  parameter int STEP_DELAY  = 3200000,
  parameter int HOLD_DELAY  = 32000000,
  parameter int IW          = 2,
  parameter int GW          = 5
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          play_i,
  input  logic          sel_match_i,
  input  logic          done_in_i,
  input  logic [1:0]    mode_i,
  output logic [IW-1:0] idx_o,
  output logic [GW-1:0] grow_o,
  output logic          active_o,
  output logic          all_mode_o,
  output logic          done_o
);

  localparam int MAXD = max3(max3(SPAWN_DELAY, STEP_DELAY, HOLD_DELAY), 1, 1);
  localparam int CW   = w_of(MAXD + 1);

  localparam int SP_L = (SPAWN_DELAY > 0) ? SPAWN_DELAY - 1 : 0;
  localparam int ST_L = (STEP_DELAY > 0) ? STEP_DELAY - 1 : 0;
  localparam int HO_L = (HOLD_DELAY > 0) ? HOLD_DELAY - 1 : 0;
  localparam int GR_L = (GROW_STEPS > 0) ? GROW_STEPS - 1 : 0;

  localparam logic [CW-1:0] SP_LAST = CW'(SP_L);
  localparam logic [CW-1:0] ST_LAST = CW'(ST_L);
  localparam logic [CW-1:0] HO_LAST = CW'(HO_L);
  localparam logic [GW-1:0] G_LAST  = GW'(GR_L);
  localparam logic [IW-1:0] IMAX    = IW'(NUM_LASERS - 1);

  state_e        state_q, state_d;
  mode_e         mode_q, mode_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [IW-1:0] idx_q, idx_d;
  logic [GW-1:0] grow_q, grow_d;
  logic          dir_q, dir_d;
  logic          done_q, done_d;
  logic          last;

  // State, counter and sequence registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_PING;
      cnt_q   <= '0;
      idx_q   <= '0;
      grow_q  <= '0;
      dir_q   <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      grow_q  <= grow_d;
      dir_q   <= dir_d;
      done_q  <= done_d;
    end
  end

  // Next-state: phase timing and sweep order
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    cnt_d   = cnt_q + CW'(1);
    idx_d   = idx_q;
    grow_d  = grow_q;
    dir_d   = dir_q;
    done_d  = 1'b0;
    last    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        cnt_d  = '0;
        grow_d = '0;
        if (done_in_i && play_i && sel_match_i) begin
          state_d = ST_SPAWN;
          mode_d  = mode_e'(mode_i);
          idx_d   = (mode_i == MODE_REV) ? IMAX : '0;
          dir_d   = 1'b0;
        end
      end
      ST_SPAWN: begin
        if (cnt_q == SP_LAST) begin
          cnt_d   = '0;
          state_d = (GROW_STEPS == 0) ? ST_HOLD : ST_GROW;
        end
      end
      ST_GROW: begin
        if (cnt_q == ST_LAST) begin
          cnt_d  = '0;
          grow_d = grow_q + GW'(1);
          if (grow_q == G_LAST) state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (cnt_q == HO_LAST) begin
          cnt_d   = '0;
          grow_d  = '0;
          state_d = ST_SPAWN;
          unique case (mode_q)
            MODE_FWD: begin
              if (idx_q == IMAX) last = 1'b1;
              else idx_d = idx_q + IW'(1);
            end
            MODE_REV: begin
              if (idx_q == '0) last = 1'b1;
              else idx_d = idx_q - IW'(1);
            end
            MODE_ALL: last = 1'b1;
            MODE_PING: begin
              if (!dir_q) begin
                if (idx_q == IMAX) dir_d = 1'b1;
                else idx_d = idx_q + IW'(1);
              end else begin
                if (idx_q == '0) last = 1'b1;
                else idx_d = idx_q - IW'(1);
              end
            end
          endcase
          if (last) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
            idx_d   = '0;
            dir_d   = 1'b0;
          end
        end
      end
    endcase
    // Losing the game aborts silently from any running phase
    if (state_q != ST_IDLE && !play_i) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
      grow_d  = '0;
      idx_d   = '0;
      dir_d   = 1'b0;
      done_d  = 1'b0;
    end
  end

  assign idx_o      = idx_q;
  assign grow_o     = grow_q;
  assign active_o   = (state_q != ST_IDLE) && play_i;
  assign all_mode_o = (mode_q == MODE_ALL);
  assign done_o     = done_q;

endmodule

// File: rtl/laser_array_obstacle.sv
// Laser array obstacle: pixel overlay of the swept lasers
// with registered colour, hit coordinates and done pulse.
module laser_array_obstacle
  import laser_array_obstacle_pkg::*;
#(
  parameter logic [2:0]  SELECT_CODE  = 3'b001,
  parameter int          NUM_LASERS   = 3,
  parameter int          FIRST_LEFT   = 411,
  parameter int          PITCH        = 100,
  parameter logic [11:0] LASER_TOP    = DEF_LASER_TOP,
  parameter logic [11:0] LASER_BOTTOM = DEF_LASER_BOTTOM,
  parameter int          GROW_STEPS   = 30,
  parameter int          SPAWN_DELAY  = 32000000,
  parameter int          STEP_DELAY   = 3200000,
  parameter int          HOLD_DELAY   = 32000000,
  parameter logic [11:0] LASER_RGB    = RGB_WHITE
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] hcount_in,
  input  logic [11:0] vcount_in,
  input  logic [11:0] rgb_in,
  input  logic        play_selected,
  input  logic [2:0]  selected,
  input  logic        done_in,
  input  logic [1:0]  mode_in,
  output logic [11:0] rgb_out,
  output logic [11:0] obstacle_x,
  output logic [11:0] obstacle_y,
  output logic        done
);

  localparam int IW = w_of(NUM_LASERS);
  localparam int GW = w_of(GROW_STEPS + 1);

  if (NUM_LASERS < 1 || NUM_LASERS > 8) begin : g_bad_n
    $error("laser_array_obstacle: NUM_LASERS must be 1..8");
  end
  if (FIRST_LEFT < GROW_STEPS ||
      FIRST_LEFT + (NUM_LASERS - 1) * PITCH + 1 + GROW_STEPS > 4095)
  begin : g_bad_geom
    $error("laser_array_obstacle: laser columns leave 0..4095");
  end

  logic [IW-1:0] idx;
  logic [GW-1:0] grow;
  logic          active;
  logic          all_mode;
  logic          seq_done;

  laser_sequencer #(
    .NUM_LASERS  (NUM_LASERS),
    .GROW_STEPS  (GROW_STEPS),
    .SPAWN_DELAY (SPAWN_DELAY),
    .STEP_DELAY  (STEP_DELAY),
    .HOLD_DELAY  (HOLD_DELAY),
    .IW          (IW),
    .GW          (GW)
  ) u_seq (
    .clk         (clk),
    .rst         (rst),
    .play_i      (play_selected),
    .sel_match_i (selected == SELECT_CODE),
    .done_in_i   (done_in),
    .mode_i      (mode_in),
    .idx_o       (idx),
    .grow_o      (grow),
    .active_o    (active),
    .all_mode_o  (all_mode),
    .done_o      (seq_done)
  );

  logic [11:0] grow12;
  logic [11:0] lft, rgt;
  logic        hit;
  logic        lit;

  assign grow12 = 12'(grow);

  // Column test against the current laser, or every laser in all-together mode
  always_comb begin
    hit = 1'b0;
    lft = '0;
    rgt = '0;
    for (int i = 0; i < NUM_LASERS; i++) begin
      lft = 12'(FIRST_LEFT + i * PITCH) - grow12;
      rgt = 12'(FIRST_LEFT + i * PITCH + 1) + grow12;
      if ((all_mode || idx == IW'(i)) &&
          hcount_in >= lft && hcount_in <= rgt)
        hit = 1'b1;
    end
  end

  assign lit = hit && active &&
               vcount_in >= LASER_TOP &&
               vcount_in <= LASER_BOTTOM;

  logic [11:0] rgb_q, x_q, y_q;

  // Registered pixel path
  always_ff @(posedge clk) begin
    if (rst) begin
      rgb_q <= '0;
      x_q   <= '0;
      y_q   <= '0;
    end else if (lit) begin
      rgb_q <= LASER_RGB;
      x_q   <= hcount_in;
      y_q   <= vcount_in;
    end else begin
      rgb_q <= rgb_in;
      x_q   <= '0;
      y_q   <= '0;
    end
  end

  assign rgb_out    = rgb_q;
  assign obstacle_x = x_q;
  assign obstacle_y = y_q;
  assign done       = seq_done;

endmodule

// File: tb/tb_laser_array_obstacle.sv
// Scoreboard bench for laser_array_obstacle with short delays.
// Expected pixels come from a per-cycle schedule of the sweep.
module tb_laser_array_obstacle;

  localparam int N = 3;
  localparam int STEP_CYC = 4 + 2 * 2 + 3;

  logic        clk = 1'b0;
  logic        rst;
  logic [11:0] hcount_in, vcount_in, rgb_in;
  logic        play_selected;
  logic [2:0]  selected;
  logic        done_in;
  logic [1:0]  mode_in;
  logic [11:0] rgb_out, obstacle_x, obstacle_y;
  logic        done;

  always #5 clk = ~clk;

  laser_array_obstacle #(
    .NUM_LASERS  (N),
    .GROW_STEPS  (2),
    .SPAWN_DELAY (4),
    .STEP_DELAY  (2),
    .HOLD_DELAY  (3)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .hcount_in     (hcount_in),
    .vcount_in     (vcount_in),
    .rgb_in        (rgb_in),
    .play_selected (play_selected),
    .selected      (selected),
    .done_in       (done_in),
    .mode_in       (mode_in),
    .rgb_out       (rgb_out),
    .obstacle_x    (obstacle_x),
    .obstacle_y    (obstacle_y),
    .done          (done)
  );

  typedef struct packed {
    logic [11:0] rgb;
    logic [11:0] x;
    logic [11:0] y;
  } pix_t;

  pix_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   ord[$];
  int   hp = 0;
  int   vtab[5] = '{316, 317, 400, 617, 618};
  int   holdh[4] = '{408, 409, 414, 415};

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic bit in_laser(int h, int v, int l, int g);
    return v >= 317 && v <= 617 &&
           h >= 411 + l * 100 - g && h <= 412 + l * 100 + g;
  endfunction

  // One pixel cycle: check done, drive pixel, push expectation, compare output
  task automatic cycle(input bit on, input int idx, input int g,
                       input bit exp_done, input int h, input int v);
    pix_t e;
    bit   hit;
    logic [11:0] c;
    @(negedge clk);
    chk("done", 32'(done), 32'(exp_done));
    if (h < 0) h = 408 + 100 * $urandom_range(0, N - 1) + $urandom_range(0, 7);
    if (v < 0) v = vtab[$urandom_range(0, 4)];
    c = 12'($urandom);
    hit = 1'b0;
    if (on)
      for (int l = 0; l < N; l++)
        if ((idx < 0 || idx == l) && in_laser(h, v, l, g)) hit = 1'b1;
    e.rgb = hit ? 12'hfff : c;
    e.x   = hit ? 12'(h) : 12'd0;
    e.y   = hit ? 12'(v) : 12'd0;
    sb_q.push_back(e);
    hcount_in = 12'(h);
    vcount_in = 12'(v);
    rgb_in    = c;
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    chk("rgb_out", 32'(rgb_out), 32'(e.rgb));
    chk("obstacle_x", 32'(obstacle_x), 32'(e.x));
    chk("obstacle_y", 32'(obstacle_y), 32'(e.y));
  endtask

  task automatic start(input logic [1:0] m);
    play_selected = 1'b1;
    selected = 3'b001;
    done_in = 1'b1;
    mode_in = m;
    cycle(1'b0, 0, 0, 1'b0, -1, -1);
    done_in = 1'b0;
    mode_in = ~m;
  endtask

  function automatic int grow_at(int o);
    return (o < 6) ? 0 : (o < 8) ? 1 : 2;
  endfunction

  // Full sweep following the order queue; stops early when stop_k >= 0
  task automatic run_seq(input logic [1:0] m, input int stop_k);
    int ns, step, o, idx, g, h, v;
    ns = ord.size();
    start(m);
    for (int k = 0; k < ns * STEP_CYC; k++) begin
      if (k == stop_k) return;
      step = k / STEP_CYC;
      o    = k % STEP_CYC;
      idx  = ord[step];
      g    = grow_at(o);
      h = -1;
      v = -1;
      if (m == 2'b01 && k == 0) begin h = 412; v = 400; end
      if (m == 2'b01 && k == 1) begin h = 412; v = 316; end
      if (m == 2'b11 && k < 6) begin
        h = 411 + (k / 2) * 100 + (k % 2);
        v = 400;
      end
      if (idx == 0 && o >= 8) begin
        h = holdh[hp % 4];
        v = 400;
        hp++;
      end
      cycle(1'b1, idx, g, 1'b0, h, v);
    end
    cycle(1'b0, 0, 0, 1'b1, -1, -1);
    cycle(1'b0, 0, 0, 1'b0, -1, -1);
    cycle(1'b0, 0, 0, 1'b0, 412, 400);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    hcount_in = 12'd412;
    vcount_in = 12'd400;
    rgb_in = 12'h5a5;
    play_selected = 1'b0;
    selected = 3'b000;
    done_in = 1'b0;
    mode_in = 2'b00;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rgb", 32'(rgb_out), 32'h0);
    chk("rst_x", 32'(obstacle_x), 32'h0);
    chk("rst_y", 32'(obstacle_y), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    cycle(1'b0, 0, 0, 1'b0, 412, 400);

    ord = '{0, 1, 2};
    run_seq(2'b01, -1);
    ord = '{0, 1, 2, 2, 1, 0};
    run_seq(2'b00, -1);
    ord = '{2, 1, 0};
    run_seq(2'b10, -1);
    ord = '{-1};
    run_seq(2'b11, -1);

    // Reset while growing
    ord = '{0, 1, 2};
    run_seq(2'b01, 5);
    @(negedge clk);
    rst = 1'b1;
    hcount_in = 12'd412;
    vcount_in = 12'd400;
    @(posedge clk);
    #1;
    chk("mid_rst_rgb", 32'(rgb_out), 32'h0);
    chk("mid_rst_x", 32'(obstacle_x), 32'h0);
    chk("mid_rst_y", 32'(obstacle_y), 32'h0);
    chk("mid_rst_done", 32'(done), 32'h0);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) cycle(1'b0, 0, 0, 1'b0, 412, 400);

    // Abort in hold
    run_seq(2'b01, 9);
    play_selected = 1'b0;
    for (int i = 0; i < 20; i++) cycle(1'b0, 0, 0, 1'b0, -1, -1);
    play_selected = 1'b1;
    for (int i = 0; i < 4; i++) cycle(1'b0, 0, 0, 1'b0, 412, 400);

    // Wrong selector never starts
    selected = 3'b010;
    done_in = 1'b1;
    mode_in = 2'b11;
    for (int i = 0; i < 15; i++) cycle(1'b0, 0, 0, 1'b0, -1, 400);
    done_in = 1'b0;

    // Clean restart after everything above
    ord = '{0, 1, 2};
    run_seq(2'b01, -1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
